// File: rtl/i2c_pkg.sv
// i2c_pkg
// Shared types and constants for the byte-level I2C master.
//   stateT   : transaction sequencer states
//   quarterT : quarter phase inside one bit-time (Q0..Q3)
//   RW_WRITE / RW_READ : transaction direction encoding
//   ACK / NACK         : SDA level during an acknowledge bit
//   ACK_BIT            : bit-counter value of the ninth (acknowledge) bit
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        DADDR,
        MADDR,
        WDATA,
        RSTART,
        RADDR,
        RDATA,
        STOP,
        DONE
    } stateT;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } quarterT;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic [3:0] ACK_BIT = 4'd8;

    // True for the byte states in which the master shifts its own byte out.
    function automatic logic isTxByte(input stateT s);
        return (s == DADDR) || (s == MADDR) || (s == WDATA) || (s == RADDR);
    endfunction

endpackage

// File: rtl/i2c_bit_timer.sv
// i2c_bit_timer
// Bit-time generator: CLK_DIV prescaler, quarter counter and strobes.
// Optional feature macro: I2C_MASTER_STRETCH_EN (clock stretching).
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   run        : counts while high, returns to Q0 / prescale 0 while low
//   sclHigh    : master is currently releasing SCL
//   scl_i      : sensed SCL (only used with stretching)
//   quarter    : current quarter phase
//   endBit     : last clk of Q3 (bit-time boundary)
//   sampleStb  : first clk of Q3, the SDA sample point
module i2c_bit_timer
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    run,
    input  logic    sclHigh,
    input  logic    scl_i,
    output quarterT quarter,
    output logic    endBit,
    output logic    sampleStb
);

    localparam int PW = $clog2(CLK_DIV);

    logic [PW-1:0] prescale;
    logic          hold;
    logic          lastCycle;

`ifdef I2C_MASTER_STRETCH_EN
    // A slave holding SCL low while we release it freezes the bit timing.
    assign hold = sclHigh && !scl_i;
`else
    logic unusedStretch;
    assign hold          = 1'b0;
    assign unusedStretch = sclHigh ^ scl_i;
`endif

    assign lastCycle = (prescale == PW'(CLK_DIV - 1));
    assign endBit    = run && !hold && lastCycle && (quarter == Q3);
    assign sampleStb = run && !hold && (quarter == Q3) && (prescale == '0);

    // Prescaler and quarter counter; both restart from zero whenever the
    // sequencer is not inside a bit so every transaction starts aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale <= '0;
            quarter  <= Q0;
        end else if (!run) begin
            prescale <= '0;
            quarter  <= Q0;
        end else if (!hold) begin
            if (lastCycle) begin
                prescale <= '0;
                quarter  <= quarterT'(quarter + 2'd1);
            end else begin
                prescale <= prescale + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl
// Byte-level I2C master issuing single-byte random write / random read.
// Optional feature macro: I2C_MASTER_STRETCH_EN (handled in i2c_bit_timer).
// Ports:
//   clk, rst_n              : system clock, asynchronous active-low reset
//   start, rw               : request pulse and direction (0 write, 1 read)
//   devAddr, memAddr, wrData: transaction fields, captured with start
//   rdData                  : last byte read
//   busy, done, ackErr      : status; ackErr valid with done
//   scl_o, sda_o            : line drives, 1 = released, 0 = pull low
//   scl_i, sda_i            : sensed line levels
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] devAddr,
    input  logic [7:0] memAddr,
    input  logic [7:0] wrData,
    output logic [7:0] rdData,
    output logic       busy,
    output logic       done,
    output logic       ackErr,
    output logic       scl_o,
    input  logic       scl_i,
    output logic       sda_o,
    input  logic       sda_i
);

    stateT      state;
    stateT      stateNext;
    quarterT    quarter;
    logic       endBit;
    logic       sampleStb;
    logic       run;
    logic       txByte;
    logic       ackBit;
    logic [3:0] bitCnt;
    logic [7:0] shiftReg;
    logic       loadEn;
    logic [7:0] loadVal;
    logic       rwReg;
    logic [6:0] devReg;
    logic [7:0] memReg;
    logic [7:0] wrReg;

    assign run    = (state != IDLE) && (state != DONE);
    assign busy   = run;
    assign done   = (state == DONE);
    assign txByte = isTxByte(state);
    assign ackBit = (bitCnt == ACK_BIT);

    i2c_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) uTimer (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .sclHigh   (scl_o),
        .scl_i     (scl_i),
        .quarter   (quarter),
        .endBit    (endBit),
        .sampleStb (sampleStb)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Sequencer: byte states advance after their ninth bit; a NACK seen in
    // that bit's ACK slot skips straight to STOP. loadEn preloads the next
    // outgoing byte so its MSB is on SDA at the first Q0 of the new state.
    always_comb begin
        stateNext = state;
        loadEn    = 1'b0;
        loadVal   = '0;
        case (state)
            IDLE: begin
                if (start) stateNext = START;
            end
            START: begin
                if (endBit) begin
                    stateNext = DADDR;
                    loadEn    = 1'b1;
                    loadVal   = {devReg, RW_WRITE};
                end
            end
            DADDR: begin
                if (endBit && ackBit) begin
                    if (ackErr) begin
                        stateNext = STOP;
                    end else begin
                        stateNext = MADDR;
                        loadEn    = 1'b1;
                        loadVal   = memReg;
                    end
                end
            end
            MADDR: begin
                if (endBit && ackBit) begin
                    if (ackErr) begin
                        stateNext = STOP;
                    end else if (rwReg == RW_READ) begin
                        stateNext = RSTART;
                    end else begin
                        stateNext = WDATA;
                        loadEn    = 1'b1;
                        loadVal   = wrReg;
                    end
                end
            end
            WDATA: begin
                if (endBit && ackBit) stateNext = STOP;
            end
            RSTART: begin
                if (endBit) begin
                    stateNext = RADDR;
                    loadEn    = 1'b1;
                    loadVal   = {devReg, RW_READ};
                end
            end
            RADDR: begin
                if (endBit && ackBit) stateNext = ackErr ? STOP : RDATA;
            end
            RDATA: begin
                if (endBit && ackBit) stateNext = STOP;
            end
            STOP: begin
                if (endBit) stateNext = DONE;
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Line drive decode. START and STOP shape SCL/SDA per quarter; data bits
    // hold SCL low for the first half so SDA only moves while SCL is low.
    always_comb begin
        scl_o = 1'b1;
        sda_o = 1'b1;
        case (state)
            START, RSTART: begin
                case (quarter)
                    Q0:      begin scl_o = 1'b0; sda_o = 1'b1; end
                    Q1:      begin scl_o = 1'b1; sda_o = 1'b1; end
                    Q2:      begin scl_o = 1'b1; sda_o = 1'b0; end
                    default: begin scl_o = 1'b0; sda_o = 1'b0; end
                endcase
            end
            STOP: begin
                case (quarter)
                    Q0:      begin scl_o = 1'b0; sda_o = 1'b0; end
                    Q1:      begin scl_o = 1'b1; sda_o = 1'b0; end
                    default: begin scl_o = 1'b1; sda_o = 1'b1; end
                endcase
            end
            DADDR, MADDR, WDATA, RADDR, RDATA: begin
                scl_o = (quarter == Q2) || (quarter == Q3);
                sda_o = (txByte && !ackBit) ? shiftReg[7] : NACK;
            end
            default: begin
                scl_o = 1'b1;
                sda_o = 1'b1;
            end
        endcase
    end

    // Datapath: request capture, bit counter, shared tx/rx shift register,
    // ACK error flag and read-data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rwReg    <= RW_WRITE;
            devReg   <= '0;
            memReg   <= '0;
            wrReg    <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
            ackErr   <= 1'b0;
            rdData   <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                rwReg  <= rw;
                devReg <= devAddr;
                memReg <= memAddr;
                wrReg  <= wrData;
                ackErr <= 1'b0;
            end

            if (stateNext != state) begin
                bitCnt <= '0;
            end else if (endBit) begin
                bitCnt <= bitCnt + 1'b1;
            end

            if (loadEn) begin
                shiftReg <= loadVal;
            end else if (endBit && txByte && !ackBit) begin
                shiftReg <= {shiftReg[6:0], 1'b0};
            end else if (sampleStb && (state == RDATA) && !ackBit) begin
                shiftReg <= {shiftReg[6:0], sda_i};
            end

            if (sampleStb && txByte && ackBit && (sda_i == NACK)) begin
                ackErr <= 1'b1;
            end

            if ((state == RDATA) && endBit && ackBit) begin
                rdData <= shiftReg;
            end
        end
    end

endmodule
